spmv_row_result_collector: RTL and testbench

SPMV_ROW_RESULT_COLLECTOR -- requirements
Module: spmv_row_result_collector

---
 rtl/spmv_row_result_collector.sv | 112 +++++++++++
 tb/tb_spmv_row_result_collector.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_result_collector.sv
// spmv_row_result_collector: buffers row-sum pairs and serialises them as one indexed row per beat.
module spmv_row_result_collector #(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int ROW_IDX_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [ROW_IDX_WIDTH-1:0]  num_rows,
    input  logic                      sum_vaild,
    input  logic [2*DATA_WIDTH-1:0]   data_sum,
    output logic                      sum_room,
    output logic                      out_vaild,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [ROW_IDX_WIDTH-1:0]  out_row,
    output logic                      out_last,
    output logic                      done,
    output logic                      overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [AW-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic                     half_q, half_d, vld_q, vld_d, ovf_q, ovf_d;
    logic [ROW_IDX_WIDTH-1:0] row_q, row_d, nrows_q, nrows_d;
    logic [2*DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [2*DATA_WIDTH-1:0]  head;
    logic                     hs, last, pop, push;

    // half_q selects the lower (odd-row) half of the head entry; an entry
    // retires when that half, or the pass's last row, handshakes.
    assign head     = mem_q[rd_q];
    assign last     = row_q == nrows_q - ROW_IDX_WIDTH'(1);
    assign hs       = vld_q && out_ready;
    assign pop      = hs && (half_q || last);
    assign push     = state_q == RUN && !start && sum_vaild && (cnt_q != FULL || pop);
    assign sum_room = cnt_q != FULL;
    assign out_vaild = vld_q;
    assign out_data = vld_q ? (half_q ? head[DATA_WIDTH-1:0] : head[2*DATA_WIDTH-1:DATA_WIDTH]) : '0;
    assign out_row  = vld_q ? row_q : '0;
    assign out_last = vld_q && last;
    assign done     = state_q == DONE;
    assign overflow = ovf_q;

    // Sum-pair storage; not reset because occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= data_sum;
    end

    // Next-state: FIFO bookkeeping, beat sequencing, pass control.
    always_comb begin
        state_d = state_q;
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        half_d  = hs ? !pop : half_q;
        row_d   = hs ? row_q + ROW_IDX_WIDTH'(1) : row_q;
        nrows_d = nrows_q;
        ovf_d   = ovf_q || (state_q == RUN && !start && sum_vaild && !push);
        if (state_q == DONE) state_d = IDLE;
        if (state_q == RUN && hs && last) begin
            state_d = DONE;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            half_d  = 1'b0;
        end
        if (start && state_q != DONE) begin
            state_d = num_rows != '0 ? RUN : DONE;
            nrows_d = num_rows;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            half_d  = 1'b0;
            row_d   = '0;
            ovf_d   = 1'b0;
        end
        // A fresh entry shows one cycle after landing; back-to-back otherwise.
        vld_d = state_d == RUN && cnt_q != '0 && cnt_d != '0;
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            row_q   <= '0;
            nrows_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            row_q   <= row_d;
            nrows_q <= nrows_d;
        end
    end
endmodule

// File: tb/tb_spmv_row_result_collector.sv
// tb_spmv_row_result_collector: scoreboard bench for the row result collector.
module tb_spmv_row_result_collector;
    localparam int W  = 32;
    localparam int D  = 4;
    localparam int RW = 16;

    logic            clk = 1'b0, rstn = 1'b0, start = 1'b0, sum_vaild = 1'b0, out_ready = 1'b0;
    logic [RW-1:0]   num_rows = '0;
    logic [2*W-1:0]  data_sum = '0;
    logic            sum_room, out_vaild, out_last, done, overflow;
    logic [W-1:0]    out_data;
    logic [RW-1:0]   out_row;

    typedef struct {
        logic [RW-1:0] row;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int checks = 0, errors = 0, exp_row = 0, exp_n = 0;

    spmv_row_result_collector #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .ROW_IDX_WIDTH(RW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .num_rows(num_rows),
        .sum_vaild(sum_vaild), .data_sum(data_sum), .sum_room(sum_room),
        .out_vaild(out_vaild), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last), .done(done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_start(input int n);
        start = 1'b1;
        num_rows = RW'(n);
        exp_row = 0;
        exp_n = n;
        sb.delete();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_beat(input logic [W-1:0] d);
        if (exp_row < exp_n) sb.push_back('{RW'(exp_row), d, exp_row == exp_n - 1});
        exp_row++;
    endtask

    task automatic expect_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        push_beat(a);
        push_beat(b);
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        sum_vaild = 1'b1;
        data_sum = {a, b};
        @(posedge clk); #1;
        sum_vaild = 1'b0;
    endtask

    // Pops the scoreboard on every accepted beat; strict also demands no bubbles.
    task automatic drain(input int budget, input bit strict);
        int cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (strict) begin
                checks++;
                if (out_vaild !== 1'b1) begin
                    errors++;
                    $display("FAIL gap: out_vaild %b want 1 at cycle %0d", out_vaild, cyc);
                end
            end
            if (out_vaild && out_ready) begin
                beat_t e = sb.pop_front();
                checks++;
                if (out_row !== e.row || out_data !== e.data || out_last !== e.last) begin
                    errors++;
                    $display("FAIL beat: got row %0d data %h last %b, want row %0d data %h last %b",
                             out_row, out_data, out_last, e.row, e.data, e.last);
                end
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still expected after %0d cycles, want 0", sb.size(), budget);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks += 7;
        if (out_vaild !== 1'b0) begin errors++; $display("FAIL rst_vaild: got %b want 0", out_vaild); end
        if (out_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", out_data); end
        if (out_row !== '0) begin errors++; $display("FAIL rst_row: got %0d want 0", out_row); end
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b want 0", out_last); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        if (sum_room !== 1'b1) begin errors++; $display("FAIL rst_room: got %b want 1", sum_room); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        do_start(4);
        expect_pair(32'h11, 32'h22);
        expect_pair(32'h33, 32'h44);
        fork
            begin send_pair(32'h11, 32'h22); send_pair(32'h33, 32'h44); end
            drain(40, 1'b0);
        join
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_vaild !== 1'b0) begin
            errors++; $display("FAIL basic_done: done %b vaild %b want 1 0", done, out_vaild);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: done %b want 0", done); end
    endtask

    task automatic test_latency();
        out_ready = 1'b0;
        do_start(2);
        expect_pair(32'h5A5A, 32'hA5A5);
        send_pair(32'h5A5A, 32'hA5A5);
        @(negedge clk);
        checks++;
        if (out_vaild !== 1'b0) begin errors++; $display("FAIL lat_early: vaild %b want 0", out_vaild); end
        @(negedge clk);
        checks++;
        if (out_vaild !== 1'b1 || out_data !== 32'h5A5A || out_row !== '0 || out_last !== 1'b0) begin
            errors++; $display("FAIL lat_first: vaild %b data %h row %0d last %b want 1 5a5a 0 0",
                               out_vaild, out_data, out_row, out_last);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_vaild !== 1'b1 || out_data !== 32'h5A5A || out_row !== '0) begin
            errors++; $display("FAIL lat_hold: vaild %b data %h row %0d want 1 5a5a 0", out_vaild, out_data, out_row);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(10, 1'b1);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL lat_done: done %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        do_start(6);
        for (int i = 0; i < 3; i++) begin
            expect_pair(32'h100 + 32'(2*i), 32'h101 + 32'(2*i));
            send_pair(32'h100 + 32'(2*i), 32'h101 + 32'(2*i));
        end
        out_ready = 1'b1;
        drain(10, 1'b1);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: done %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_odd();
        int seen = 0;
        out_ready = 1'b1;
        do_start(3);
        expect_pair(32'hA, 32'hB);
        expect_pair(32'hC, 32'hD);
        fork
            begin send_pair(32'hA, 32'hB); send_pair(32'hC, 32'hD); end
            drain(40, 1'b0);
        join
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL odd_done: done %b want 1", done); end
        repeat (3) begin
            @(negedge clk);
            if (out_vaild) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL odd_extra: %0d extra beats want 0", seen); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        do_start(10);
        for (int i = 0; i < 4; i++) send_pair(32'(i), 32'(i + 10));
        @(negedge clk);
        checks++;
        if (sum_room !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_full: room %b ovf %b want 0 0", sum_room, overflow);
        end
        @(posedge clk); #1;
        send_pair(32'hDEAD, 32'hBEEF);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: ovf %b want 1", overflow); end
        do_start(2);
        @(negedge clk);
        checks++;
        if (out_vaild !== 1'b0 || overflow !== 1'b0 || sum_room !== 1'b1) begin
            errors++; $display("FAIL ovf_restart: vaild %b ovf %b room %b want 0 0 1", out_vaild, overflow, sum_room);
        end
        @(posedge clk); #1;
        expect_pair(32'h77, 32'h88);
        send_pair(32'h77, 32'h88);
        out_ready = 1'b1;
        drain(20, 1'b0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ovf_done: done %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_full_accept();
        out_ready = 1'b0;
        do_start(10);
        for (int i = 0; i < 4; i++) begin
            expect_pair(32'h200 + 32'(i), 32'h300 + 32'(i));
            send_pair(32'h200 + 32'(i), 32'h300 + 32'(i));
        end
        @(negedge clk);
        checks++;
        if (sum_room !== 1'b0) begin errors++; $display("FAIL fa_full: room %b want 0", sum_room); end
        expect_pair(32'hE1, 32'hE2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            begin @(posedge clk); #1; send_pair(32'hE1, 32'hE2); end
            drain(40, 1'b1);
        join
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL fa_accept: ovf %b done %b want 0 1", overflow, done);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        num_rows = '0;
        #2;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL zero_early: done %b want 0", done); end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_vaild !== 1'b0) begin
            errors++; $display("FAIL zero_done: done %b vaild %b want 1 0", done, out_vaild);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || out_vaild !== 1'b0) begin
            errors++; $display("FAIL zero_pulse: done %b vaild %b want 0 0", done, out_vaild);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b0;
        do_start(8);
        send_pair(32'h1, 32'h2);
        send_pair(32'h3, 32'h4);
        @(negedge clk);
        checks++;
        if (out_vaild !== 1'b1) begin errors++; $display("FAIL rm_pre: vaild %b want 1", out_vaild); end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (out_vaild !== 1'b0 || out_data !== '0 || out_row !== '0 || out_last !== 1'b0 ||
            done !== 1'b0 || overflow !== 1'b0 || sum_room !== 1'b1) begin
            errors++; $display("FAIL rm_async: vaild %b data %h row %0d last %b done %b ovf %b room %b want 0 0 0 0 0 0 1",
                               out_vaild, out_data, out_row, out_last, done, overflow, sum_room);
        end
        out_ready = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_vaild) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rm_partial: %0d beats after reset want 0", seen); end
        @(posedge clk); #1;
        send_pair(32'hFF, 32'hFF);
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0 || out_vaild !== 1'b0 || sum_room !== 1'b1) begin
            errors++; $display("FAIL idle_ignore: ovf %b vaild %b room %b want 0 0 1", overflow, out_vaild, sum_room);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_back_to_back();
        test_odd();
        test_overflow();
        test_full_accept();
        test_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
